// File: rtl/layer_input_sequencer.sv
// Purpose : captures one input vector, then replays it once per output node as
//           serial (weight, data) beats, with weights fetched from an external RAM.
// Latency : fixed 2 cycles from o_weight_rd_en to o_valid; NIN gap-free beats per node.
// Backpr. : none inside a burst; the next node starts only after i_node_done in WAIT.
// Ports   : clk/rst_n (async active-low); i_valid/i_data input-vector words;
//           o_weight_rd_en/o_weight_addr/i_weight_rdata weight RAM (1-cycle read);
//           i_node_done from layer; o_valid/o_weight/o_data beats; o_busy, o_done status.
module layer_input_sequencer #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_INPUT_NODE  = 3,
  parameter int NUMBER_OF_OUTPUT_NODE = 32,
  parameter int ADDR_WIDTH            = $clog2(NUMBER_OF_INPUT_NODE*NUMBER_OF_OUTPUT_NODE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_weight_rd_en,
  output logic [ADDR_WIDTH-1:0] o_weight_addr,
  input  logic [DATA_WIDTH-1:0] i_weight_rdata,
  input  logic                  i_node_done,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NIN = NUMBER_OF_INPUT_NODE;
  localparam int NOUT = NUMBER_OF_OUTPUT_NODE;
  localparam int KW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int NW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NIN - 1);
  localparam logic [NW-1:0] LAST_NODE = NW'(NOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_WAIT} state_t;

  state_t                  state, next_state;
  logic [KW-1:0]           in_cnt;
  logic [KW-1:0]           k;
  logic [NW-1:0]           node;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [KW-1:0]           rd_k;      // buffer index travelling with the issued read
  logic [KW-1:0]           pipe_k;    // same index, aligned with RAM data
  logic                    pipe_vld;  // RAM data valid this cycle
  logic [DATA_WIDTH-1:0]   vec [NIN];
  logic                    accept;

  // A node_done only counts once every beat of the burst has drained out of
  // the read pipeline, so a pulse during or right after streaming is dropped.
  assign accept = (state == S_WAIT) && i_node_done &&
                  !o_weight_rd_en && !pipe_vld && !o_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (i_valid) next_state = (NIN == 1) ? S_STREAM : S_LOAD;
      S_LOAD:   if (i_valid && (in_cnt == LAST_K)) next_state = S_STREAM;
      S_STREAM: if (k == LAST_K) next_state = S_WAIT;
      S_WAIT:   if (accept) next_state = (node == LAST_NODE) ? S_IDLE : S_STREAM;
      default:  next_state = S_IDLE;
    endcase
  end

  // Status outputs; o_done fires in the accepting WAIT cycle, so an i_valid
  // arriving in that same cycle is not captured.
  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = accept && (node == LAST_NODE);
  end

  // Counters, read issue and beat pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt         <= '0;
      k              <= '0;
      node           <= '0;
      addr_cnt       <= '0;
      rd_k           <= '0;
      pipe_k         <= '0;
      pipe_vld       <= 1'b0;
      o_weight_rd_en <= 1'b0;
      o_weight_addr  <= '0;
      o_valid        <= 1'b0;
      o_weight       <= '0;
      o_data         <= '0;
    end else begin
      o_weight_rd_en <= (state == S_STREAM);
      pipe_vld       <= o_weight_rd_en;
      pipe_k         <= rd_k;
      o_valid        <= pipe_vld;
      if (pipe_vld) begin
        o_weight <= i_weight_rdata;
        o_data   <= vec[pipe_k];
      end
      case (state)
        S_IDLE: begin
          k        <= '0;
          node     <= '0;
          addr_cnt <= '0;
          if (i_valid) in_cnt <= KW'(1);
        end
        S_LOAD: begin
          if (i_valid) in_cnt <= in_cnt + 1'b1;
        end
        S_STREAM: begin
          // Reads for consecutive nodes are contiguous, so a running counter
          // yields node*NIN+k without a multiplier.
          o_weight_addr <= addr_cnt;
          addr_cnt      <= addr_cnt + 1'b1;
          rd_k          <= k;
          k             <= (k == LAST_K) ? '0 : k + 1'b1;
        end
        S_WAIT: begin
          if (accept && (node != LAST_NODE)) node <= node + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Input vector buffer; written only while loading, so it holds through all bursts.
  always_ff @(posedge clk) begin
    if (i_valid && (state == S_IDLE))      vec[0]      <= i_data;
    else if (i_valid && (state == S_LOAD)) vec[in_cnt] <= i_data;
  end

endmodule

// File: tb/tb_layer_input_sequencer.sv
// Purpose : directed self-checking bench for layer_input_sequencer (NIN=3, NOUT=2).
// Latency : checks the 2-cycle rd_en->o_valid latency and gap-free bursts.
// Backpr. : exercises early/ignored i_node_done and i_valid outside the load phase.
module tb_layer_input_sequencer;
  localparam int DW = 32;
  localparam int NIN = 3;
  localparam int NOUT = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_weight_rd_en;
  logic [AW-1:0] o_weight_addr;
  logic [DW-1:0] i_weight_rdata = '0;
  logic          i_node_done = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_weight;
  logic [DW-1:0] o_data;
  logic          o_busy;
  logic          o_done;

  layer_input_sequencer #(
    .DATA_WIDTH(DW), .NUMBER_OF_INPUT_NODE(NIN),
    .NUMBER_OF_OUTPUT_NODE(NOUT), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_weight_rd_en(o_weight_rd_en), .o_weight_addr(o_weight_addr),
    .i_weight_rdata(i_weight_rdata), .i_node_done(i_node_done),
    .o_valid(o_valid), .o_weight(o_weight), .o_data(o_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Weight RAM model: RAM[a] = a, one cycle read latency
  always @(posedge clk) if (o_weight_rd_en) i_weight_rdata <= 32'(o_weight_addr);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [DW-1:0] bw[$];
  logic [DW-1:0] bd[$];
  logic [AW-1:0] ra[$];
  int bcyc[$];
  int rcyc[$];

  // Monitor: samples on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (o_valid) begin bw.push_back(o_weight); bd.push_back(o_data); bcyc.push_back(cyc); end
    if (o_weight_rd_en) begin ra.push_back(o_weight_addr); rcyc.push_back(cyc); end
    if (o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bw.delete(); bd.delete(); ra.delete(); bcyc.delete(); rcyc.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    i_valid = 1'b1; i_data = d;
    step(1);
    i_valid = 1'b0;
    step(gap);
  endtask

  task automatic pulse_done();
    i_node_done = 1'b1;
    step(1);
    i_node_done = 1'b0;
  endtask

  // Returns just after the posedge that follows the n-th beat's sample.
  task automatic wait_beats(input int n, input string tag);
    int b = 0;
    while (bw.size() < n && b < 200) begin @(posedge clk); b++; end
    #1;
    chk({tag, " beat_timeout"}, 32'(bw.size() >= n), 32'd1);
  endtask

  task automatic run_vector(input logic [DW-1:0] d0, d1, d2, input int gap, input string tag);
    send(d0, gap); send(d1, gap); send(d2, gap);
    for (int n = 0; n < NOUT; n++) begin
      wait_beats(NIN * (n + 1), tag);
      step(5);
      pulse_done();
    end
    step(2);
  endtask

  task automatic check_stream(input logic [DW-1:0] d0, d1, d2, input string tag);
    logic [DW-1:0] d [NIN];
    d[0] = d0; d[1] = d1; d[2] = d2;
    chk({tag, " beat_count"}, 32'(bw.size()), 32'(NIN * NOUT));
    for (int i = 0; i < NIN * NOUT; i++) begin
      chk($sformatf("%s weight%0d", tag, i), bw[i], 32'(i));
      chk($sformatf("%s data%0d", tag, i), bd[i], d[i % NIN]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'($urandom); i_data = $urandom; i_node_done = 1'($urandom);
      step(1);
      chk("rst flags", {28'd0, o_valid, o_weight_rd_en, o_busy, o_done}, 32'd0);
      chk("rst weight", o_weight, 32'd0);
      chk("rst data", o_data, 32'd0);
      chk("rst addr", 32'(o_weight_addr), 32'd0);
    end
    i_valid = 1'b0; i_data = '0; i_node_done = 1'b0;
    rst_n = 1'b1;
    step(3);
    chk("post_rst busy", 32'(o_busy), 32'd0);
    chk("post_rst valid", 32'(o_valid), 32'd0);

    // 2: back-to-back input words
    clear_mon();
    run_vector(32'hA, 32'hB, 32'hC, 0, "s2");
    check_stream(32'hA, 32'hB, 32'hC, "s2");
    for (int i = 0; i < NIN * NOUT; i++) chk($sformatf("s2 addr%0d", i), 32'(ra[i]), 32'(i));
    chk("s2 latency", 32'(bcyc[0] - rcyc[0]), 32'd2);
    chk("s2 no_bubble", 32'(bcyc[2] - bcyc[0]), 32'd2);
    chk("s2 done_cnt", 32'(done_cnt), 32'd1);
    chk("s2 busy_end", 32'(o_busy), 32'd0);

    // 3: input words with 2-cycle gaps
    clear_mon();
    run_vector(32'hA, 32'hB, 32'hC, 2, "s3");
    check_stream(32'hA, 32'hB, 32'hC, "s3");
    chk("s3 done_cnt", 32'(done_cnt), 32'd1);

    // 4+5: early node_done pulses ignored; garbage i_valid outside load ignored
    clear_mon();
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 0);
    i_valid = 1'b1; i_data = 32'hDEAD_BEEF;
    pulse_done();                         // during STREAM
    wait_beats(2, "s4");
    pulse_done();                         // coincides with the last beat
    step(10);
    chk("s4 reads_held", 32'(rcyc.size()), 32'(NIN));
    chk("s4 beats_held", 32'(bw.size()), 32'(NIN));
    chk("s4 busy_wait", 32'(o_busy), 32'd1);
    pulse_done();                         // accepted in WAIT
    wait_beats(2 * NIN, "s4");
    step(5);
    i_data = 32'h77;                      // presented in the o_done cycle
    i_node_done = 1'b1;
    step(1);
    i_node_done = 1'b0; i_valid = 1'b0;
    step(2);
    check_stream(32'h11, 32'h22, 32'h33, "s4");
    chk("s4 done_cnt", 32'(done_cnt), 32'd1);
    chk("s4 word_not_captured", 32'(o_busy), 32'd0);

    // 6: reset mid-burst of node 1, then a fresh vector
    clear_mon();
    send(32'hD, 0); send(32'hE, 0); send(32'hF, 0);
    wait_beats(NIN, "s6");
    step(5);
    pulse_done();
    wait_beats(NIN + 1, "s6");
    rst_n = 1'b0;
    #1;
    chk("s6 rst flags", {28'd0, o_valid, o_weight_rd_en, o_busy, o_done}, 32'd0);
    chk("s6 rst weight", o_weight, 32'd0);
    chk("s6 rst data", o_data, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    clear_mon();
    run_vector(32'h21, 32'h22, 32'h23, 0, "s6b");
    check_stream(32'h21, 32'h22, 32'h23, "s6b");
    chk("s6b first_addr", 32'(ra[0]), 32'd0);
    chk("s6b done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
